// File: rtl/soc_system_pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL lock sequencer.
package soc_system_pll_seq_pkg;

  typedef enum logic [2:0] {
    StPllRst   = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StRun      = 3'd3,
    StFault    = 3'd4
  } pll_seq_state_e;

  // Width of the shared timer: enough to hold the largest terminal count (max-1).
  function automatic int unsigned timer_width(input int unsigned rst_cycles,
                                              input int unsigned lock_timeout,
                                              input int unsigned stable_cycles);
    int unsigned m;
    m = rst_cycles;
    if (lock_timeout > m) m = lock_timeout;
    if (stable_cycles > m) m = stable_cycles;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/soc_system_pll_lock_sync.sv
// Multi-flop synchronizer for the asynchronous PLL locked indication.
module soc_system_pll_lock_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic sync_out
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/soc_system_pll_lock_sequencer.sv
// Sequences PLL reset, waits for stable lock, then releases the stream-domain reset.
module soc_system_pll_lock_sequencer
  import soc_system_pll_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 65536,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pll_locked,
  input  logic             sw_restart,
  output logic             pll_rst,
  output logic             stream_reset_n,
  output logic             fault,
  output logic             locked_stable,
  output logic [CNT_W-1:0] lock_lost_count,
  output logic [2:0]       state_o
);

  localparam int unsigned TimerW = timer_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int unsigned RetryW = $clog2(MAX_RETRIES + 1);

  localparam logic [TimerW-1:0] RstLast     = TimerW'(PLL_RST_CYCLES - 1);
  localparam logic [TimerW-1:0] TimeoutLast = TimerW'(LOCK_TIMEOUT - 1);
  localparam logic [TimerW-1:0] StableLast  = TimerW'(STABLE_CYCLES - 1);
  localparam logic [RetryW-1:0] RetryLast   = RetryW'(MAX_RETRIES - 1);

  pll_seq_state_e    state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pll_rst_q, stream_reset_n_q, fault_q, locked_stable_q;
  logic              locked_s;

  soc_system_pll_lock_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .async_in(pll_locked),
    .sync_out(locked_s)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    cnt_d   = cnt_q;
    if (sw_restart) begin
      state_d = StPllRst;
      timer_d = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        StPllRst: begin
          if (timer_q == RstLast) begin
            state_d = StWaitLock;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TimerW'(1);
          end
        end
        StWaitLock: begin
          // Lock beats a simultaneous timeout.
          if (locked_s) begin
            state_d = StStable;
            timer_d = '0;
          end else if (timer_q == TimeoutLast) begin
            timer_d = '0;
            retry_d = retry_q + RetryW'(1);
            state_d = (retry_q == RetryLast) ? StFault : StPllRst;
          end else begin
            timer_d = timer_q + TimerW'(1);
          end
        end
        StStable: begin
          if (!locked_s) begin
            state_d = StWaitLock;
            timer_d = '0;
          end else if (timer_q == StableLast) begin
            state_d = StRun;
            timer_d = '0;
            retry_d = '0;
          end else begin
            timer_d = timer_q + TimerW'(1);
          end
        end
        StRun: begin
          if (!locked_s) begin
            state_d = StPllRst;
            timer_d = '0;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StFault: ;
        default: begin
          state_d = StPllRst;
          timer_d = '0;
          retry_d = '0;
        end
      endcase
    end
  end

  // Outputs are flopped from the next state so they always match the state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q          <= StPllRst;
      timer_q          <= '0;
      retry_q          <= '0;
      cnt_q            <= '0;
      pll_rst_q        <= 1'b1;
      stream_reset_n_q <= 1'b0;
      fault_q          <= 1'b0;
      locked_stable_q  <= 1'b0;
    end else begin
      state_q          <= state_d;
      timer_q          <= timer_d;
      retry_q          <= retry_d;
      cnt_q            <= cnt_d;
      pll_rst_q        <= (state_d == StPllRst);
      stream_reset_n_q <= (state_d == StRun);
      fault_q          <= (state_d == StFault);
      locked_stable_q  <= (state_d == StRun);
    end
  end

  assign pll_rst         = pll_rst_q;
  assign stream_reset_n  = stream_reset_n_q;
  assign fault           = fault_q;
  assign locked_stable   = locked_stable_q;
  assign lock_lost_count = cnt_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_soc_system_pll_lock_sequencer.sv
// Directed self-checking bench for the PLL lock sequencer.
module tb_soc_system_pll_lock_sequencer;

  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             pll_locked;
  logic             sw_restart;
  logic             pll_rst;
  logic             stream_reset_n;
  logic             fault;
  logic             locked_stable;
  logic [CNT_W-1:0] lock_lost_count;
  logic [2:0]       state_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  soc_system_pll_lock_sequencer #(
    .SYNC_STAGES   (2),
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT  (32),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2),
    .CNT_W         (CNT_W)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pll_locked     (pll_locked),
    .sw_restart     (sw_restart),
    .pll_rst        (pll_rst),
    .stream_reset_n (stream_reset_n),
    .fault          (fault),
    .locked_stable  (locked_stable),
    .lock_lost_count(lock_lost_count),
    .state_o        (state_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (state_o !== target && n < budget);
    chk(tag, 32'(state_o), 32'(target));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(state_o), 32'd0);
    chk({tag, "_pll_rst"}, 32'(pll_rst), 32'd1);
    chk({tag, "_stream_rst_n"}, 32'(stream_reset_n), 32'd0);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
    chk({tag, "_locked_stable"}, 32'(locked_stable), 32'd0);
    chk({tag, "_count"}, 32'(lock_lost_count), 32'd0);
  endtask

  initial begin
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    sw_restart = 1'b0;
    repeat (2) tick();
    chk_reset_vals("rst");

    // Lock present from reset release.
    pll_locked = 1'b1;
    reset_n    = 1'b1;
    repeat (3) begin
      tick();
      chk("t1_pll_rst_hold", 32'(pll_rst), 32'd1);
    end
    tick();
    chk("t1_wait_lock", 32'(state_o), 32'd1);
    chk("t1_pll_rst_low", 32'(pll_rst), 32'd0);
    tick();
    chk("t1_stable_entry", 32'(state_o), 32'd2);
    repeat (7) tick();
    chk("t1_still_stable", 32'(state_o), 32'd2);
    chk("t1_stream_held", 32'(stream_reset_n), 32'd0);
    tick();
    chk("t1_run", 32'(state_o), 32'd3);
    chk("t1_stream_rel", 32'(stream_reset_n), 32'd1);
    chk("t1_locked_stable", 32'(locked_stable), 32'd1);
    chk("t1_count", 32'(lock_lost_count), 32'd0);

    // Lock loss in RUN: two sync cycles, then PLL restart.
    pll_locked = 1'b0;
    repeat (2) tick();
    chk("t4_run_sync", 32'(state_o), 32'd3);
    chk("t4_stream_up", 32'(stream_reset_n), 32'd1);
    tick();
    chk("t4_pll_rst", 32'(state_o), 32'd0);
    chk("t4_pll_rst_hi", 32'(pll_rst), 32'd1);
    chk("t4_stream_dn", 32'(stream_reset_n), 32'd0);
    chk("t4_count1", 32'(lock_lost_count), 32'd1);

    for (int i = 2; i <= 256; i++) begin
      pll_locked = 1'b1;
      wait_state(3'd3, 60, "t4_reach_run");
      pll_locked = 1'b0;
      wait_state(3'd0, 10, "t4_restart");
      if (i == 2) chk("t4_count2", 32'(lock_lost_count), 32'd2);
      if (i == 255) chk("t4_count255", 32'(lock_lost_count), 32'd255);
    end
    chk("t4_count_sat", 32'(lock_lost_count), 32'd255);

    // Glitch in STABLE: lock drops for three cycles, no PLL reset, full requalification.
    pll_locked = 1'b1;
    repeat (4) tick();
    chk("t3_wait_lock", 32'(state_o), 32'd1);
    tick();
    chk("t3_stable", 32'(state_o), 32'd2);
    repeat (4) tick();
    chk("t3_stable5", 32'(state_o), 32'd2);
    pll_locked = 1'b0;
    repeat (2) tick();
    chk("t3_stable_sync", 32'(state_o), 32'd2);
    tick();
    chk("t3_back_wait", 32'(state_o), 32'd1);
    chk("t3_no_pll_rst", 32'(pll_rst), 32'd0);
    pll_locked = 1'b1;
    repeat (2) tick();
    chk("t3_wait_sync", 32'(state_o), 32'd1);
    tick();
    chk("t3_restable", 32'(state_o), 32'd2);
    repeat (7) tick();
    chk("t3_full_requal", 32'(state_o), 32'd2);
    chk("t3_stream_held", 32'(stream_reset_n), 32'd0);
    tick();
    chk("t3_run", 32'(state_o), 32'd3);
    chk("t3_stream_rel", 32'(stream_reset_n), 32'd1);

    // sw_restart in RUN.
    sw_restart = 1'b1;
    tick();
    sw_restart = 1'b0;
    chk("t5_run_restart", 32'(state_o), 32'd0);
    chk("t5_run_stream", 32'(stream_reset_n), 32'd0);
    chk("t5_run_count", 32'(lock_lost_count), 32'd255);

    // Reset mid-STABLE.
    repeat (5) tick();
    chk("t6_stable", 32'(state_o), 32'd2);
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    tick();
    chk_reset_vals("t6_rst");
    reset_n = 1'b1;
    repeat (3) begin
      tick();
      chk("t6_pll_rst_hold", 32'(pll_rst), 32'd1);
    end
    tick();
    chk("t6_wait_lock", 32'(state_o), 32'd1);
    chk("t6_pll_rst_low", 32'(pll_rst), 32'd0);

    // Lock never arrives; a sw_restart during PLL_RST restarts the hold and clears retry.
    repeat (31) tick();
    chk("t2_wait32", 32'(state_o), 32'd1);
    tick();
    chk("t2_retry1", 32'(state_o), 32'd0);
    repeat (2) tick();
    chk("t5_pllrst_mid", 32'(state_o), 32'd0);
    sw_restart = 1'b1;
    tick();
    sw_restart = 1'b0;
    repeat (3) begin
      tick();
      chk("t5_rehold", 32'(pll_rst), 32'd1);
    end
    tick();
    chk("t5_rehold_end", 32'(state_o), 32'd1);
    repeat (31) tick();
    chk("t2_wait_a", 32'(state_o), 32'd1);
    tick();
    chk("t2_retry_cleared", 32'(state_o), 32'd0);
    chk("t2_no_fault_yet", 32'(fault), 32'd0);
    repeat (3) tick();
    chk("t2_pulse2", 32'(pll_rst), 32'd1);
    tick();
    chk("t2_wait_b0", 32'(state_o), 32'd1);
    repeat (31) tick();
    chk("t2_wait_b", 32'(state_o), 32'd1);
    chk("t2_fault_lo", 32'(fault), 32'd0);
    tick();
    chk("t2_fault_state", 32'(state_o), 32'd4);
    chk("t2_fault", 32'(fault), 32'd1);
    chk("t2_fault_pll_rst", 32'(pll_rst), 32'd0);
    chk("t2_fault_stream", 32'(stream_reset_n), 32'd0);
    repeat (20) tick();
    chk("t2_fault_held", 32'(state_o), 32'd4);
    chk("t2_fault_held_f", 32'(fault), 32'd1);

    // Recovery from FAULT: retry restarts from zero.
    sw_restart = 1'b1;
    tick();
    sw_restart = 1'b0;
    chk("t5_fault_exit", 32'(state_o), 32'd0);
    chk("t5_fault_clr", 32'(fault), 32'd0);
    chk("t5_fault_pll_rst", 32'(pll_rst), 32'd1);
    repeat (3) tick();
    tick();
    chk("t5_f_wait", 32'(state_o), 32'd1);
    repeat (31) tick();
    chk("t5_f_wait32", 32'(state_o), 32'd1);
    tick();
    chk("t5_f_retry0", 32'(state_o), 32'd0);
    pll_locked = 1'b1;
    wait_state(3'd3, 60, "t5_relock_run");
    pll_locked = 1'b0;
    wait_state(3'd0, 10, "t5_relock_loss");
    chk("t5_count_after_rst", 32'(lock_lost_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
